// File: rtl/isa_pkg.sv
// ISA constants for the multi-cycle controller: opcodes, ALU codes, states, instruction classes.
package isa_pkg;

  // Opcode encodings (fit in the 6-bit default opcode field)
  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_MUL   = 2;
  localparam int OP_AND   = 3;
  localparam int OP_OR    = 4;
  localparam int OP_ADDI  = 5;
  localparam int OP_LDB   = 10;
  localparam int OP_LDW   = 11;
  localparam int OP_STB   = 12;
  localparam int OP_STW   = 13;
  localparam int OP_MOV   = 14;
  localparam int OP_BEQ   = 20;
  localparam int OP_JUMP  = 21;
  localparam int OP_TLBW  = 30;
  localparam int OP_IRET  = 31;

  // ALU control codes
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_MUL = 2;
  localparam int ALU_AND = 3;
  localparam int ALU_OR  = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE  = 4'd0,
    CL_RTYPE = 4'd1,
    CL_ADDI  = 4'd2,
    CL_LOAD  = 4'd3,
    CL_STORE = 4'd4,
    CL_BEQ   = 4'd5,
    CL_JUMP  = 4'd6,
    CL_TLBW  = 4'd7,
    CL_IRET  = 4'd8
  } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> instruction class, ALU control, legality.
module ctrl_decode
  import isa_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int ALU_CTRL_W = 4
) (
  input  logic [OP_W-1:0]       i_op,
  output iclass_t               o_class,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
  output logic                  o_legal
);

  // Map each defined opcode to its class and ALU operation; anything else is illegal
  always_comb begin
    o_class    = CL_NONE;
    o_alu_ctrl = ALU_CTRL_W'(ALU_ADD);
    o_legal    = 1'b1;
    case (i_op)
      OP_W'(OP_ADD):  begin o_class = CL_RTYPE; o_alu_ctrl = ALU_CTRL_W'(ALU_ADD); end
      OP_W'(OP_SUB):  begin o_class = CL_RTYPE; o_alu_ctrl = ALU_CTRL_W'(ALU_SUB); end
      OP_W'(OP_MUL):  begin o_class = CL_RTYPE; o_alu_ctrl = ALU_CTRL_W'(ALU_MUL); end
      OP_W'(OP_AND):  begin o_class = CL_RTYPE; o_alu_ctrl = ALU_CTRL_W'(ALU_AND); end
      OP_W'(OP_OR):   begin o_class = CL_RTYPE; o_alu_ctrl = ALU_CTRL_W'(ALU_OR);  end
      OP_W'(OP_ADDI): o_class = CL_ADDI;
      OP_W'(OP_LDB),
      OP_W'(OP_LDW):  o_class = CL_LOAD;
      OP_W'(OP_STB),
      OP_W'(OP_STW),
      OP_W'(OP_MOV):  o_class = CL_STORE;
      OP_W'(OP_BEQ):  begin o_class = CL_BEQ; o_alu_ctrl = ALU_CTRL_W'(ALU_SUB); end
      OP_W'(OP_JUMP): o_class = CL_JUMP;
      OP_W'(OP_TLBW): o_class = CL_TLBW;
      OP_W'(OP_IRET): o_class = CL_IRET;
      default:        o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath strobes,
// memory hold handshake with bounded stall timeout, and illegal-opcode trapping.
module multicycle_control
  import isa_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int ALU_CTRL_W = 4,
  parameter int MEM_TMO    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_W-1:0]       op,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  reg_dest,
  output logic                  alu_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  branch,
  output logic                  tlb_write,
  output logic                  iret,
  output logic                  hold,
  output logic                  illegal_op,
  output logic                  bus_err
);

  localparam int CNT_W = (MEM_TMO > 0) ? $clog2(MEM_TMO + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(MEM_TMO);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [OP_W-1:0]  r_op;
  logic [CNT_W-1:0] r_stall;
  logic             r_post_rst;

  state_t           w_next_state;
  logic [OP_W-1:0]  w_op_next;
  logic [CNT_W-1:0] w_stall_next;
  logic [CNT_W-1:0] w_stall_inc;
  logic             w_timeout;

  iclass_t               w_class;
  logic [ALU_CTRL_W-1:0] w_alu;
  logic                  w_legal;

  logic w_pc_write, w_ir_write, w_reg_dest, w_alu_src, w_mem_read, w_mem_write;
  logic w_mem_to_reg, w_reg_write, w_branch, w_tlb_write, w_iret, w_hold;
  logic w_illegal_op, w_bus_err;
  logic [ALU_CTRL_W-1:0] w_alu_ctrl;

  // Outputs decode only the latched opcode, never the live op input
  ctrl_decode #(
    .OP_W       (OP_W),
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_decode (
    .i_op       (r_op),
    .o_class    (w_class),
    .o_alu_ctrl (w_alu),
    .o_legal    (w_legal)
  );

  assign w_stall_inc = (r_stall == CNT_MAX) ? r_stall : r_stall + CNT_W'(1);
  assign w_timeout   = (MEM_TMO != 0) && (r_stall == CNT_TMO) &&
                       ((r_state == ST_FETCH) || (r_state == ST_MEM));

  // Next-state, opcode capture, stall counting and Moore strobe decode
  always_comb begin
    w_next_state = r_state;
    w_op_next    = r_op;
    w_stall_next = r_stall;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dest   = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_ctrl   = '0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_branch     = 1'b0;
    w_tlb_write  = 1'b0;
    w_iret       = 1'b0;
    w_hold       = 1'b0;
    w_illegal_op = 1'b0;
    w_bus_err    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (w_timeout) begin
          w_bus_err    = 1'b1;
          w_stall_next = '0;
        end else begin
          w_mem_read = 1'b1;
          w_hold     = ~mem_ready;
          if (mem_ready) begin
            w_stall_next = '0;
            // The opcode is captured with the IR load so DECODE strobes come from registered state;
            // the first cycle after reset only issues the read request.
            if (!r_post_rst) begin
              w_ir_write   = 1'b1;
              w_pc_write   = 1'b1;
              w_op_next    = op;
              w_next_state = ST_DECODE;
            end else begin
              w_next_state = ST_FETCH;
            end
          end else begin
            w_stall_next = w_stall_inc;
          end
        end
      end
      ST_DECODE: begin
        if (!w_legal) begin
          w_illegal_op = 1'b1;
          w_next_state = ST_FETCH;
        end else begin
          case (w_class)
            CL_TLBW: begin w_tlb_write = 1'b1; w_next_state = ST_FETCH; end
            CL_IRET: begin w_iret      = 1'b1; w_next_state = ST_FETCH; end
            default: w_next_state = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        w_alu_ctrl = w_alu;
        case (w_class)
          CL_RTYPE: begin w_reg_dest = 1'b1; w_next_state = ST_WB;  end
          CL_ADDI:  begin w_alu_src  = 1'b1; w_next_state = ST_WB;  end
          CL_LOAD,
          CL_STORE: begin w_alu_src  = 1'b1; w_next_state = ST_MEM; end
          CL_BEQ:   begin w_branch   = zero; w_next_state = ST_FETCH; end
          CL_JUMP:  begin w_branch   = 1'b1; w_next_state = ST_FETCH; end
          default:  w_next_state = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (w_timeout) begin
          w_bus_err    = 1'b1;
          w_stall_next = '0;
          w_next_state = ST_FETCH;
        end else begin
          w_mem_read  = (w_class == CL_LOAD);
          w_mem_write = (w_class == CL_STORE);
          w_hold      = ~mem_ready;
          if (mem_ready) begin
            w_stall_next = '0;
            w_next_state = (w_class == CL_LOAD) ? ST_WB : ST_FETCH;
          end else begin
            w_stall_next = w_stall_inc;
          end
        end
      end
      ST_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dest   = (w_class == CL_RTYPE);
        w_mem_to_reg = (w_class == CL_LOAD);
        w_next_state = ST_FETCH;
      end
      default: w_next_state = ST_FETCH;
    endcase
  end

  // State, opcode latch, stall counter and post-reset marker
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_op       <= '0;
      r_stall    <= '0;
      r_post_rst <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_op       <= w_op_next;
      r_stall    <= w_stall_next;
      r_post_rst <= 1'b0;
    end
  end

  // Every output is forced low while reset is asserted
  assign pc_write   = w_pc_write   & ~rst;
  assign ir_write   = w_ir_write   & ~rst;
  assign reg_dest   = w_reg_dest   & ~rst;
  assign alu_src    = w_alu_src    & ~rst;
  assign alu_ctrl   = rst ? '0 : w_alu_ctrl;
  assign mem_read   = w_mem_read   & ~rst;
  assign mem_write  = w_mem_write  & ~rst;
  assign mem_to_reg = w_mem_to_reg & ~rst;
  assign reg_write  = w_reg_write  & ~rst;
  assign branch     = w_branch     & ~rst;
  assign tlb_write  = w_tlb_write  & ~rst;
  assign iret       = w_iret       & ~rst;
  assign hold       = w_hold       & ~rst;
  assign illegal_op = w_illegal_op & ~rst;
  assign bus_err    = w_bus_err    & ~rst;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (default parameters, MEM_TMO=15).
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic pc_write, ir_write, reg_dest, alu_src, mem_read, mem_write, mem_to_reg;
  logic reg_write, branch, tlb_write, iret, hold, illegal_op, bus_err;
  logic [3:0] alu_ctrl;

  int n_total = 0;
  int n_bad   = 0;

  // Output bit masks, packed in the order of w_outs below
  localparam logic [13:0] PCW  = 14'h2000;
  localparam logic [13:0] IRW  = 14'h1000;
  localparam logic [13:0] RDST = 14'h0800;
  localparam logic [13:0] ASRC = 14'h0400;
  localparam logic [13:0] MRD  = 14'h0200;
  localparam logic [13:0] MWR  = 14'h0100;
  localparam logic [13:0] M2R  = 14'h0080;
  localparam logic [13:0] RWR  = 14'h0040;
  localparam logic [13:0] BR   = 14'h0020;
  localparam logic [13:0] TLB  = 14'h0010;
  localparam logic [13:0] IRT  = 14'h0008;
  localparam logic [13:0] HLD  = 14'h0004;
  localparam logic [13:0] ILL  = 14'h0002;
  localparam logic [13:0] BERR = 14'h0001;
  localparam logic [13:0] NONE = 14'h0000;
  localparam logic [13:0] FETCH_OK = MRD | IRW | PCW;

  logic [13:0] w_outs;
  assign w_outs = {pc_write, ir_write, reg_dest, alu_src, mem_read, mem_write, mem_to_reg,
                   reg_write, branch, tlb_write, iret, hold, illegal_op, bus_err};

  multicycle_control #(
    .OP_W       (6),
    .ALU_CTRL_W (4),
    .MEM_TMO    (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_dest   (reg_dest),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .branch     (branch),
    .tlb_write  (tlb_write),
    .iret       (iret),
    .hold       (hold),
    .illegal_op (illegal_op),
    .bus_err    (bus_err)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check one cycle at the falling edge, then advance past the next rising edge
  task automatic cyc(input string tag, input logic [13:0] e_out, input logic [3:0] e_alu);
    @(negedge clk);
    chk({tag, "/out"}, 32'(w_outs), 32'(e_out));
    chk({tag, "/alu"}, 32'(alu_ctrl), 32'(e_alu));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_a", NONE, 4'd0);
    cyc("rst_b", NONE, 4'd0);
    rst = 1'b0;
    // First cycle after reset: read request only, no IR/PC load
    cyc("post_rst", MRD, 4'd0);

    // ADD: FETCH, DECODE, EXEC, WB
    op = 6'd0;
    cyc("add_f", FETCH_OK, 4'd0);
    cyc("add_d", NONE, 4'd0);
    cyc("add_e", RDST, 4'd0);
    cyc("add_w", RWR | RDST, 4'd0);

    // MUL: alu_ctrl follows the R-type opcode
    op = 6'd2;
    cyc("mul_f", FETCH_OK, 4'd0);
    cyc("mul_d", NONE, 4'd0);
    cyc("mul_e", RDST, 4'd2);
    cyc("mul_w", RWR | RDST, 4'd0);

    // ADDI: immediate operand, rt destination
    op = 6'd5;
    cyc("addi_f", FETCH_OK, 4'd0);
    cyc("addi_d", NONE, 4'd0);
    cyc("addi_e", ASRC, 4'd0);
    cyc("addi_w", RWR, 4'd0);

    // LDW with three stall cycles in MEM: 8 cycles total
    op = 6'd11;
    cyc("ldw_f", FETCH_OK, 4'd0);
    cyc("ldw_d", NONE, 4'd0);
    cyc("ldw_e", ASRC, 4'd0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ldw_stall", MRD | HLD, 4'd0);
    mem_ready = 1'b1;
    cyc("ldw_m", MRD, 4'd0);
    cyc("ldw_w", RWR | M2R, 4'd0);

    // BEQ taken and not taken
    op = 6'd20; zero = 1'b1;
    cyc("beq1_f", FETCH_OK, 4'd0);
    cyc("beq1_d", NONE, 4'd0);
    cyc("beq1_e", BR, 4'd1);
    zero = 1'b0;
    cyc("beq0_f", FETCH_OK, 4'd0);
    cyc("beq0_d", NONE, 4'd0);
    cyc("beq0_e", NONE, 4'd1);

    // JUMP
    op = 6'd21;
    cyc("jmp_f", FETCH_OK, 4'd0);
    cyc("jmp_d", NONE, 4'd0);
    cyc("jmp_e", BR, 4'd0);

    // Illegal opcode 7
    op = 6'd7;
    cyc("ill_f", FETCH_OK, 4'd0);
    cyc("ill_d", ILL, 4'd0);

    // TLBWRITE and IRET single-cycle strobes
    op = 6'd30;
    cyc("tlb_f", FETCH_OK, 4'd0);
    cyc("tlb_d", TLB, 4'd0);
    op = 6'd31;
    cyc("iret_f", FETCH_OK, 4'd0);
    cyc("iret_d", IRT, 4'd0);

    // STB and MOV with no stall: 4 cycles each
    op = 6'd12;
    cyc("stb_f", FETCH_OK, 4'd0);
    cyc("stb_d", NONE, 4'd0);
    cyc("stb_e", ASRC, 4'd0);
    cyc("stb_m", MWR, 4'd0);
    op = 6'd14;
    cyc("mov_f", FETCH_OK, 4'd0);
    cyc("mov_d", NONE, 4'd0);
    cyc("mov_e", ASRC, 4'd0);
    cyc("mov_m", MWR, 4'd0);

    // STW with memory never ready: 15 hold cycles, then bus_err, then FETCH
    op = 6'd13;
    cyc("stw_f", FETCH_OK, 4'd0);
    cyc("stw_d", NONE, 4'd0);
    cyc("stw_e", ASRC, 4'd0);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("stw_stall", MWR | HLD, 4'd0);
    cyc("stw_berr", BERR, 4'd0);
    cyc("stw_refetch", MRD | HLD, 4'd0);
    mem_ready = 1'b1;
    // LDB: reset asserted for 3 cycles in the middle of a MEM stall
    op = 6'd10;
    cyc("ldb_f", FETCH_OK, 4'd0);
    cyc("ldb_d", NONE, 4'd0);
    cyc("ldb_e", ASRC, 4'd0);
    mem_ready = 1'b0;
    cyc("ldb_stall0", MRD | HLD, 4'd0);
    cyc("ldb_stall1", MRD | HLD, 4'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc("rst_mid", NONE, 4'd0);
    rst = 1'b0;
    cyc("rst_fetch", MRD | HLD, 4'd0);
    mem_ready = 1'b1;
    cyc("ldb2_f", FETCH_OK, 4'd0);
    cyc("ldb2_d", NONE, 4'd0);
    cyc("ldb2_e", ASRC, 4'd0);
    cyc("ldb2_m", MRD, 4'd0);
    cyc("ldb2_w", RWR | M2R, 4'd0);
    cyc("ldb2_next", FETCH_OK, 4'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
